// File: rtl/axi_wr_slave.sv
// axi_wr_slave: AXI3 write-channel slave backed by a byte-enabled local memory.
// Accepts one AW burst at a time, absorbs its W beats, then returns one B response.
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-low reset
//   awvalid/awready, awid, awaddr, awlen, awsize, awburst   write address channel
//   wvalid/wready, wid, wdata, wstrb, wlast                 write data channel
//   bvalid/bready, bid, bresp                               write response channel
//   dbg_addr, dbg_data            combinational debug read of one memory word
module axi_wr_slave #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 3,
  parameter int unsigned DEPTH = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [WIDTH/8-1:0]         awid,
  input  logic [WIDTH-1:0]           awaddr,
  input  logic [WIDTH/8-1:0]         awlen,
  input  logic [SIZE-1:0]            awsize,
  input  logic [SIZE-2:0]            awburst,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [WIDTH/8-1:0]         wid,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [WIDTH/8-1:0]         wstrb,
  input  logic                       wlast,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [WIDTH/8-1:0]         bid,
  output logic [SIZE-2:0]            bresp,
  input  logic [$clog2(DEPTH)-1:0]   dbg_addr,
  output logic [WIDTH-1:0]           dbg_data
);

  localparam int unsigned IDW = WIDTH / 8;
  localparam int unsigned BW  = SIZE - 1;
  localparam int unsigned DAW = $clog2(DEPTH);
  localparam int unsigned LGB = $clog2(WIDTH / 8);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t           state, state_d;
  logic             awready_d, wready_d, bvalid_d;
  logic [IDW-1:0]   bid_d, id_q, id_d, len_q, len_d, cnt_q, cnt_d;
  logic [BW-1:0]    bresp_d, burst_q, burst_d;
  logic [SIZE-1:0]  size_q, size_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             slverr_q, slverr_d, decerr_q, decerr_d;
  logic             mem_we;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] aw_n, nbytes, wrap_b, next_addr;
  logic             len_ok, aw_slv, aw_dec, beat_slv, beat_dec, beat_last;

  assign dbg_data = mem[dbg_addr];

  // Burst-legality checks evaluated on the incoming AW fields.
  always_comb begin
    aw_n   = WIDTH'(1) << awsize;
    len_ok = (awlen == IDW'(1)) || (awlen == IDW'(3)) ||
             (awlen == IDW'(7)) || (awlen == IDW'(15));
    aw_slv = (awburst == BW'(3)) || (awsize > SIZE'(LGB)) ||
             ((awburst == BW'(2)) && (!len_ok || ((awaddr & (aw_n - WIDTH'(1))) != '0)));
    aw_dec = (awaddr >> LGB) >= WIDTH'(DEPTH);
  end

  // Per-beat checks and next beat address.
  always_comb begin
    nbytes    = WIDTH'(1) << size_q;
    wrap_b    = (WIDTH'(len_q) + WIDTH'(1)) << size_q;
    beat_dec  = (addr_q >> LGB) >= WIDTH'(DEPTH);
    beat_slv  = (wid != id_q) || (wlast != (cnt_q == len_q));
    beat_last = (cnt_q == len_q) || wlast;
    case (burst_q)
      BW'(1):  next_addr = (addr_q & ~(nbytes - WIDTH'(1))) + nbytes;
      BW'(2):  next_addr = (addr_q & ~(wrap_b - WIDTH'(1))) |
                           ((addr_q + nbytes) & (wrap_b - WIDTH'(1)));
      default: next_addr = addr_q;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state;
    awready_d = awready;
    wready_d  = wready;
    bvalid_d  = bvalid;
    bid_d     = bid;
    bresp_d   = bresp;
    id_d      = id_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    slverr_d  = slverr_q;
    decerr_d  = decerr_q;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready) begin
          id_d      = awid;
          addr_d    = awaddr;
          len_d     = awlen;
          size_d    = awsize;
          burst_d   = awburst;
          cnt_d     = '0;
          slverr_d  = aw_slv;
          decerr_d  = aw_dec;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (wvalid && wready) begin
          // A beat that raises an error is itself discarded.
          mem_we   = !(slverr_q || decerr_q || beat_slv || beat_dec);
          slverr_d = slverr_q || beat_slv;
          decerr_d = decerr_q || beat_dec;
          if (beat_last) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = decerr_d ? BW'(3) : (slverr_d ? BW'(2) : BW'(0));
            state_d  = RESP;
          end else begin
            cnt_d  = cnt_q + IDW'(1);
            addr_d = next_addr;
          end
        end
      end
      RESP: begin
        if (bvalid && bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
      id_q     <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      slverr_q <= 1'b0;
      decerr_q <= 1'b0;
    end else begin
      state    <= state_d;
      awready  <= awready_d;
      wready   <= wready_d;
      bvalid   <= bvalid_d;
      bid      <= bid_d;
      bresp    <= bresp_d;
      id_q     <= id_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      slverr_q <= slverr_d;
      decerr_q <= decerr_d;
    end
  end

  // Byte-enabled memory write; contents survive reset.
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      for (int i = 0; i < IDW; i++) begin
        if (wstrb[i]) mem[addr_q[LGB +: DAW]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule
